// File: rtl/prog_oscillator.sv
// Programmable clock generator with period/high-time shadow registers.
// Supports continuous output or counted bursts, with changes applied on period boundaries.
module prog_oscillator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ena,
    input  logic             i_mode,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_period,
    input  logic [WIDTH-1:0] i_high,
    input  logic [CNT_W-1:0] i_burst,
    output logic             o_out,
    output logic             o_tick,
    output logic             o_done,
    output logic             o_running
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_ARMWAIT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_per;
    logic [WIDTH-1:0] r_hi;
    logic [CNT_W-1:0] r_rem;
    logic             r_burst_mode;
    logic [WIDTH-1:0] r_sh_per;
    logic [WIDTH-1:0] r_sh_hi;
    logic [CNT_W-1:0] r_sh_burst;
    logic             r_ena_prev;
    logic             r_out;
    logic             r_tick;
    logic             r_done;

    state_t           w_next_state;
    logic [WIDTH-1:0] w_next_count;
    logic [WIDTH-1:0] w_next_per;
    logic [WIDTH-1:0] w_next_hi;
    logic [CNT_W-1:0] w_next_rem;
    logic             w_next_mode;
    logic             w_next_done;
    logic             w_next_out;
    logic             w_next_tick;
    logic             w_ena_rise;
    logic             w_boundary;
    logic [WIDTH-1:0] w_clamp_per;
    logic [WIDTH-1:0] w_high_min;
    logic [WIDTH-1:0] w_clamp_hi;

    // Clamp so that every loaded waveform has at least one high and one low cycle.
    assign w_clamp_per = (i_period < TWO) ? TWO : i_period;
    assign w_high_min  = (i_high == '0) ? ONE : i_high;
    assign w_clamp_hi  = (w_high_min > (w_clamp_per - ONE)) ? (w_clamp_per - ONE) : w_high_min;

    assign w_ena_rise = i_ena & ~r_ena_prev;
    assign w_boundary = (r_count == (r_per - ONE));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh_per   <= TWO;
            r_sh_hi    <= ONE;
            r_sh_burst <= CNT_ONE;
        end else if (i_load) begin
            r_sh_per   <= w_clamp_per;
            r_sh_hi    <= w_clamp_hi;
            r_sh_burst <= i_burst;
        end
    end

    // ENA history keeps tracking during reset so a level held through reset is not an edge.
    always_ff @(posedge i_clk) begin
        r_ena_prev <= i_ena;
    end

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_next_per   = r_per;
        w_next_hi    = r_hi;
        w_next_rem   = r_rem;
        w_next_mode  = r_burst_mode;
        w_next_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_count = '0;
                if (!i_mode && i_ena) begin
                    w_next_state = S_RUN;
                    w_next_mode  = 1'b0;
                    w_next_per   = r_sh_per;
                    w_next_hi    = r_sh_hi;
                    w_next_rem   = '0;
                end else if (i_mode && w_ena_rise) begin
                    w_next_mode = 1'b1;
                    if (r_sh_burst != '0) begin
                        w_next_state = S_RUN;
                        w_next_per   = r_sh_per;
                        w_next_hi    = r_sh_hi;
                        w_next_rem   = r_sh_burst;
                    end else begin
                        w_next_state = S_ARMWAIT;
                        w_next_done  = 1'b1;
                        w_next_rem   = '0;
                    end
                end
            end
            S_RUN: begin
                if (w_boundary) begin
                    w_next_count = '0;
                    if (!r_burst_mode) begin
                        if (i_ena) begin
                            w_next_per = r_sh_per;
                            w_next_hi  = r_sh_hi;
                        end else begin
                            w_next_state = S_IDLE;
                        end
                    end else if (r_rem > CNT_ONE) begin
                        w_next_rem = r_rem - CNT_ONE;
                        w_next_per = r_sh_per;
                        w_next_hi  = r_sh_hi;
                    end else begin
                        w_next_state = S_ARMWAIT;
                        w_next_rem   = '0;
                        w_next_done  = 1'b1;
                    end
                end else begin
                    w_next_count = r_count + ONE;
                end
            end
            S_ARMWAIT: begin
                if (!i_ena) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_count = '0;
                w_next_rem   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the new phase.
    assign w_next_out  = (w_next_state == S_RUN) && (w_next_count < w_next_hi);
    assign w_next_tick = (w_next_state == S_RUN) && (w_next_count == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_per        <= TWO;
            r_hi         <= ONE;
            r_rem        <= '0;
            r_burst_mode <= 1'b0;
            r_out        <= 1'b0;
            r_tick       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_count      <= w_next_count;
            r_per        <= w_next_per;
            r_hi         <= w_next_hi;
            r_rem        <= w_next_rem;
            r_burst_mode <= w_next_mode;
            r_out        <= w_next_out;
            r_tick       <= w_next_tick;
            r_done       <= w_next_done;
        end
    end

    assign o_out     = r_out;
    assign o_tick    = r_tick;
    assign o_done    = r_done;
    assign o_running = (r_state != S_IDLE);

endmodule

// File: tb/tb_prog_oscillator.sv
// Self-checking bench for prog_oscillator: directed scenarios plus random traffic
// compared against an integer reference model of the oscillator behaviour.
module tb_prog_oscillator;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high;
    logic [CNT_W-1:0] burst;
    logic             out;
    logic             tick;
    logic             done;
    logic             running;

    int checks = 0;
    int errors = 0;

    int mPhase, mLen, mHigh, mLeft, mShP, mShH, mShB;
    bit mRunning, mArmed, mBurstMode, mPrevEna;
    bit expOut, expTick, expDone, expRun;

    prog_oscillator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_mode(mode), .i_load(load),
        .i_period(period), .i_high(high), .i_burst(burst),
        .o_out(out), .o_tick(tick), .o_done(done), .o_running(running)
    );

    always #5 clk = ~clk;

    function automatic int clampP(int p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic int clampH(int h, int p);
        int v;
        v = (h < 1) ? 1 : h;
        return (v > p - 1) ? p - 1 : v;
    endfunction

    // Reference model: one waveform period at a time, evaluated with the inputs of the coming edge.
    task automatic modelStep();
        int nP, nH, nB;
        bit rise;
        nP = clampP(int'(period));
        nH = clampH(int'(high), nP);
        nB = int'(burst);
        expDone = 0;
        if (rst) begin
            mRunning = 0; mArmed = 0; mPhase = 0; mLeft = 0;
            mShP = 2; mShH = 1; mShB = 1;
        end else begin
            rise = ena && !mPrevEna;
            if (mRunning) begin
                if (mPhase == mLen - 1) begin
                    mPhase = 0;
                    if (!mBurstMode) begin
                        if (ena) begin mLen = mShP; mHigh = mShH; end
                        else mRunning = 0;
                    end else if (mLeft > 1) begin
                        mLeft = mLeft - 1; mLen = mShP; mHigh = mShH;
                    end else begin
                        mRunning = 0; mArmed = 1; expDone = 1; mLeft = 0;
                    end
                end else begin
                    mPhase = mPhase + 1;
                end
            end else if (mArmed) begin
                if (!ena) mArmed = 0;
            end else if (!mode && ena) begin
                mRunning = 1; mBurstMode = 0; mPhase = 0; mLen = mShP; mHigh = mShH;
            end else if (mode && rise) begin
                mBurstMode = 1;
                if (mShB != 0) begin
                    mRunning = 1; mPhase = 0; mLeft = mShB; mLen = mShP; mHigh = mShH;
                end else begin
                    mArmed = 1; expDone = 1;
                end
            end
            if (load) begin mShP = nP; mShH = nH; mShB = nB; end
        end
        mPrevEna = ena;
        expOut  = mRunning && (mPhase < mHigh);
        expTick = mRunning && (mPhase == 0);
        expRun  = mRunning || mArmed;
    endtask

    task automatic advance();
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyReset(input bit enaLevel);
        rst = 1; ena = enaLevel; load = 0;
        advance();
        advance();
        rst = 0;
    endtask

    task automatic test_reset();
        applyReset(1'b1);
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_out got %b want 0", out); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
        for (int i = 0; i < 6; i++) begin
            advance();
            checks++;
            if (out !== ((i % 2) == 0) || tick !== ((i % 2) == 0)) begin
                errors++; $display("FAIL default_wave cycle %0d got out=%b tick=%b want %b", i, out, tick, (i % 2) == 0);
            end
        end
        ena = 0;
        advance();
        advance();
    endtask

    task automatic test_continuous();
        applyReset(1'b0);
        mode = 0; load = 1; period = 5; high = 2;
        advance();
        load = 0; ena = 1;
        advance();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (out !== ((i % 5) < 2) || tick !== ((i % 5) == 0) || running !== 1'b1) begin
                errors++; $display("FAIL cont_wave cycle %0d got out=%b tick=%b run=%b want out=%b", i, out, tick, running, (i % 5) < 2);
            end
            if (i < 11) advance();
        end
        ena = 0;
        for (int j = 0; j < 3; j++) begin
            advance();
            checks++;
            if (out !== 1'b0 || running !== 1'b1) begin
                errors++; $display("FAIL cont_finish step %0d got out=%b run=%b want out=0 run=1", j, out, running);
            end
        end
        advance();
        checks++;
        if (out !== 1'b0 || running !== 1'b0 || tick !== 1'b0) begin
            errors++; $display("FAIL cont_stop got out=%b run=%b tick=%b want 0 0 0", out, running, tick);
        end
    endtask

    task automatic test_clamp();
        applyReset(1'b0);
        mode = 0; load = 1; period = 0; high = 9;
        advance();
        load = 0; ena = 1;
        advance();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out !== ((i % 2) == 0)) begin
                errors++; $display("FAIL clamp_p0 cycle %0d got %b want %b", i, out, (i % 2) == 0);
            end
            advance();
        end
        ena = 0;
        advance();
        advance();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL clamp_idle got %b want 0", running); end
        load = 1; period = 4; high = 0;
        advance();
        load = 0; ena = 1;
        advance();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out !== ((i % 4) == 0)) begin
                errors++; $display("FAIL clamp_h0 cycle %0d got %b want %b", i, out, (i % 4) == 0);
            end
            advance();
        end
        ena = 0;
        for (int i = 0; i < 5; i++) advance();
    endtask

    task automatic test_burst();
        int ticks, dones;
        applyReset(1'b0);
        mode = 1; load = 1; period = 3; high = 1; burst = 3;
        advance();
        load = 0;
        advance();
        ena = 1;
        advance();
        ticks = 0;
        for (int i = 0; i < 9; i++) begin
            ticks += int'(tick);
            checks++;
            if (out !== ((i % 3) == 0) || done !== 1'b0) begin
                errors++; $display("FAIL burst_wave cycle %0d got out=%b done=%b want out=%b done=0", i, out, done, (i % 3) == 0);
            end
            advance();
        end
        checks++; if (ticks != 3) begin errors++; $display("FAIL burst_ticks got %0d want 3", ticks); end
        checks++;
        if (done !== 1'b1 || out !== 1'b0 || running !== 1'b1) begin
            errors++; $display("FAIL burst_done got done=%b out=%b run=%b want 1 0 1", done, out, running);
        end
        ticks = 0; dones = 0;
        for (int i = 0; i < 8; i++) begin
            advance();
            ticks += int'(tick); dones += int'(done);
        end
        checks++;
        if (ticks != 0 || dones != 0 || running !== 1'b1) begin
            errors++; $display("FAIL burst_hold got ticks=%0d dones=%0d run=%b want 0 0 1", ticks, dones, running);
        end
        ena = 0;
        advance();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL burst_rearm got run=%b want 0", running); end
        ena = 1;
        advance();
        ticks = 0; dones = 0;
        for (int i = 0; i < 12; i++) begin
            ticks += int'(tick); dones += int'(done);
            advance();
        end
        checks++;
        if (ticks != 3 || dones != 1) begin
            errors++; $display("FAIL burst_again got ticks=%0d dones=%0d want 3 1", ticks, dones);
        end
        ena = 0;
        advance();
    endtask

    task automatic test_boundary_update();
        int tickPos[$];
        int expPos[7];
        expPos = '{0, 4, 10, 16, 22, 25, 28};
        applyReset(1'b0);
        mode = 0; load = 1; period = 4; high = 2;
        advance();
        load = 0; ena = 1;
        advance();
        for (int s = 0; s <= 30; s++) begin
            if (tick === 1'b1) tickPos.push_back(s);
            load = 0;
            if (s == 1) begin load = 1; period = 6; high = 2; end
            if (s == 15) begin load = 1; period = 3; high = 1; end
            advance();
        end
        load = 0;
        checks++;
        if (tickPos.size() != 7) begin
            errors++; $display("FAIL boundary_count got %0d want 7", tickPos.size());
        end
        for (int k = 0; k < 7; k++) begin
            if (k < tickPos.size()) begin
                checks++;
                if (tickPos[k] != expPos[k]) begin
                    errors++; $display("FAIL boundary_tick%0d got %0d want %0d", k, tickPos[k], expPos[k]);
                end
            end
        end
        ena = 0;
        for (int i = 0; i < 4; i++) advance();
    endtask

    task automatic test_reset_mid();
        int ticks, dones, runs;
        applyReset(1'b0);
        mode = 1; load = 1; period = 3; high = 1; burst = 3;
        advance();
        load = 0; ena = 1;
        advance();
        advance();
        advance();
        advance();
        checks++; if (out !== 1'b1 || tick !== 1'b1) begin errors++; $display("FAIL rstmid_pulse2 got out=%b tick=%b want 1 1", out, tick); end
        rst = 1;
        advance();
        checks++;
        if (out !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rstmid_abort got out=%b run=%b done=%b want 0 0 0", out, running, done);
        end
        rst = 0;
        ticks = 0; dones = 0; runs = 0;
        for (int i = 0; i < 6; i++) begin
            advance();
            ticks += int'(tick); dones += int'(done); runs += int'(running);
        end
        checks++;
        if (ticks != 0 || dones != 0 || runs != 0) begin
            errors++; $display("FAIL rstmid_nostart got ticks=%0d dones=%0d runs=%0d want 0 0 0", ticks, dones, runs);
        end
        ena = 0;
        advance();
        ena = 1;
        advance();
        checks++; if (out !== 1'b1 || tick !== 1'b1) begin errors++; $display("FAIL rstmid_restart got out=%b tick=%b want 1 1", out, tick); end
        advance();
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL rstmid_low got %b want 0", out); end
        advance();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done got %b want 1", done); end
        ena = 0;
        advance();
    endtask

    task automatic test_random();
        applyReset(1'b0);
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 99) == 0);
            load = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) ena = ~ena;
            if ($urandom_range(0, 40) == 0) mode = ~mode;
            period = WIDTH'($urandom_range(0, 9));
            high   = WIDTH'($urandom_range(0, 10));
            burst  = CNT_W'($urandom_range(0, 4));
            advance();
            checks++;
            if (out !== expOut || tick !== expTick || done !== expDone || running !== expRun) begin
                errors++;
                $display("FAIL random cycle %0d got out=%b tick=%b done=%b run=%b want %b %b %b %b",
                         c, out, tick, done, running, expOut, expTick, expDone, expRun);
            end
        end
        rst = 0; load = 0;
    endtask

    initial begin
        rst = 1; ena = 0; mode = 0; load = 0;
        period = '0; high = '0; burst = '0;
        mPhase = 0; mLen = 2; mHigh = 1; mLeft = 0; mShP = 2; mShH = 1; mShB = 1;
        mRunning = 0; mArmed = 0; mBurstMode = 0; mPrevEna = 0;
        test_reset();
        test_continuous();
        test_clamp();
        test_burst();
        test_boundary_update();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_oscillator.md
PROG_OSCILLATOR -- requirements
Module: prog_oscillator

Interface
REQ-001 Parameter WIDTH, 8, width of the PERIOD and HIGH fields; SHALL be 2..16.
REQ-002 Parameter CNT_W, 8, width of the BURST pulse count.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports:
- CLK  in  1  sole clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ENA  in  1  run request; level in continuous mode, rising edge in burst mode.
- MODE  in  1  0 = continuous, 1 = burst; sampled at start only.
- LOAD  in  1  1-cycle strobe; captures PERIOD, HIGH and BURST into shadow registers.
- PERIOD  in  WIDTH  output period in CLK cycles.
- HIGH  in  WIDTH  high time in CLK cycles.
- BURST  in  CNT_W  pulses per burst.
- OUT  out  1  generated clock, registered, glitch-free.
- TICK  out  1  1-cycle pulse on the cycle OUT rises.
- DONE  out  1  1-cycle pulse when a burst completes.
- RUNNING  out  1  high whenever the FSM is not IDLE.

Function
REQ-004 LOAD SHALL capture the clamped values into the shadow registers on the cycle LOAD is high: P = max(PERIOD, 2); H = min(max(HIGH, 1), P-1).
REQ-005 Active registers SHALL take the shadow values only at start from IDLE or at a period boundary, never mid-period.
REQ-006 The FSM SHALL have three states: IDLE, RUN, ARMWAIT.
REQ-007 IDLE -> RUN: in continuous mode when ENA=1; in burst mode on an ENA 0->1 edge with BURST shadow != 0. Latency is 1 cycle from the qualifying ENA sample to OUT=1 and TICK=1.
REQ-008 In RUN, the phase counter SHALL run 0..P-1; OUT=1 while count < H, else 0; TICK=1 on each cycle where count = 0.
REQ-009 At count = P-1 the block SHALL do one of the following:
- Continuous mode, ENA=1: wrap count to 0 and start a new period.
- Continuous mode, ENA=0: go to IDLE with OUT=0. A period is never truncated, so deasserting ENA mid-period completes it.
- Burst mode, remaining > 1: decrement remaining and wrap. ENA is ignored during a burst.
- Burst mode, last pulse: go to ARMWAIT, DONE=1 for 1 cycle, OUT=0.
REQ-010 ARMWAIT -> IDLE SHALL occur when ENA=0. A new burst requires a fresh ENA rising edge.
REQ-011 A burst start with BURST shadow = 0 SHALL produce no OUT high, pulse DONE 1 cycle after the edge, and enter ARMWAIT.
REQ-012 MODE changes while RUN SHALL be ignored until the next start from IDLE.
REQ-013 LOAD and a period boundary in the same cycle: the boundary SHALL use the old shadow values; the new values apply at the following boundary.
REQ-014 Count and remaining-pulse arithmetic SHALL be unsigned with no wrap beyond P-1. The maximum P is 2^WIDTH-1.

Reset
REQ-015 RST=1 SHALL, on the next edge, force IDLE with OUT=0, TICK=0, DONE=0, RUNNING=0, count=0, remaining=0. Shadow registers reset to P=2, H=1, BURST=1.
REQ-016 Reset mid-period SHALL abort immediately without completing the period. RST has priority over LOAD and ENA.
REQ-017 After RST deasserts, a burst start requires an ENA rising edge observed after reset. ENA already high at reset release does not start a burst.

Verification
REQ-018 Reset defaults: RST for 2 cycles, ENA=1, MODE=0 -> OUT toggles with period 2, duty 1/2. TICK every 2 cycles.
REQ-019 Continuous: LOAD with PERIOD=5, HIGH=2 while idle; ENA=1 -> OUT = 1,1,0,0,0 repeating. ENA=0 at count 1 -> the period completes, then OUT=0 and RUNNING=0.
REQ-020 Clamping: LOAD with PERIOD=0, HIGH=9 -> P=2, H=1. LOAD with PERIOD=4, HIGH=0 -> H=1.
REQ-021 Burst: LOAD with PERIOD=3, HIGH=1, BURST=3; MODE=1; ENA rises -> exactly 3 TICKs, DONE on the cycle after the last period. Holding ENA high -> no restart; ENA low then high -> a new 3-pulse burst.
REQ-022 Boundary update: running with P=4; LOAD with PERIOD=6 mid-period -> the current period stays 4 and the next period is 6. LOAD coinciding with the boundary -> the change is deferred one period.
REQ-023 Reset mid-operation: RST during the second pulse of a burst -> OUT=0 next cycle, no DONE. ENA held high -> no start until an ENA rising edge.
